mtl_timing_gen_param: RTL and testbench

Parametrised LCD timing and pixel-path controller for the MTL panel.
- Generalises the fixed 800x480 controller: timing, colour depth, fetch lead and colour source are parameters or run-time modes.
- Produces sync and data-enable signals and requests pixels from an SDRAM read FIFO with fixed latency.
- Muxes four colour sources, flags FIFO underflow and counts frames.
- Sits between the SDRAM read port / sprite generators and the LCD pins.

---
 rtl/mtl_timing_gen_param.sv | 159 +++++++++++++++
 tb/tb_mtl_timing_gen_param.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtl_timing_gen_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mtl_timing_gen_param                                          |
// | Purpose  : Parametrised MTL LCD timing generator and pixel-path mux.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mtl_timing_gen_param #(
  parameter int          H_ACTIVE      = 800,
  parameter int          H_BLANK       = 46,
  parameter int          H_FP          = 210,
  parameter int          H_SYNC        = 1,
  parameter int          V_ACTIVE      = 480,
  parameter int          V_BLANK       = 23,
  parameter int          V_FP          = 22,
  parameter int          V_SYNC        = 1,
  parameter int          CW            = 8,
  parameter int          FETCH_LAT     = 1,
  parameter int          FRAME_W       = 16,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic [1:0]          iMODE,
  input  logic [3*CW-1:0]     iSOLID,
  input  logic [3*CW-1:0]     iDATA,
  input  logic                iDATA_VALID,
  input  logic [3*CW-1:0]     iOVL,
  input  logic                iOVL_KEY,
  input  logic                iCLR_ERR,
  output logic                oREQ,
  output logic [10:0]         oX,
  output logic [9:0]          oY,
  output logic                oNewFrame,
  output logic                oEndFrame,
  output logic                oHD,
  output logic                oVD,
  output logic                oDE,
  output logic [CW-1:0]       oLCD_R,
  output logic [CW-1:0]       oLCD_G,
  output logic [CW-1:0]       oLCD_B,
  output logic                oUNDERFLOW,
  output logic [FRAME_W-1:0]  oFRAME_CNT
);

  localparam int c_h_total = H_BLANK + H_ACTIVE + H_FP;
  localparam int c_v_total = V_BLANK + V_ACTIVE + V_FP;
  // x needs headroom for the fetch-lead comparison x+FETCH_LAT
  localparam int c_xw = $clog2(c_h_total + FETCH_LAT);
  localparam int c_yw = $clog2(c_v_total);

  logic [c_xw-1:0]    r_x;
  logic [c_yw-1:0]    r_y;
  logic [1:0]         r_mode;
  logic               r_uf;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic [3*CW-1:0]    r_s1_pix;
  logic               r_s1_de;
  logic               r_s1_hd;
  logic               r_s1_vd;

  logic               w_h_act;
  logic               w_v_act;
  logic               w_active;
  logic [c_xw-1:0]    w_x_lead;
  logic               w_req_col;
  logic               w_uf_evt;
  logic [2:0]         w_bar;
  logic [3*CW-1:0]    w_bar_rgb;
  logic [3*CW-1:0]    w_uf_rgb;
  logic [3*CW-1:0]    w_pix;

  assign w_h_act  = (r_x >= c_xw'(H_BLANK)) && (r_x < c_xw'(H_BLANK + H_ACTIVE));
  assign w_v_act  = (r_y >= c_yw'(V_BLANK)) && (r_y < c_yw'(V_BLANK + V_ACTIVE));
  assign w_active = w_h_act && w_v_act;

  assign w_x_lead  = r_x + c_xw'(FETCH_LAT);
  assign w_req_col = (w_x_lead >= c_xw'(H_BLANK)) && (w_x_lead < c_xw'(H_BLANK + H_ACTIVE));
  assign oREQ      = (r_mode == 2'd1) && w_v_act && w_req_col;

  assign oX = w_active ? 11'(r_x - c_xw'(H_BLANK)) : 11'd0;
  assign oY = w_active ? 10'(r_y - c_yw'(V_BLANK)) : 10'd0;

  assign oNewFrame = (r_x == '0) && (r_y == '0);
  assign oEndFrame = (r_x == c_xw'(H_BLANK + H_ACTIVE - 1)) &&
                     (r_y == c_yw'(V_BLANK + V_ACTIVE - 1));

  // Bar order white..black maps each channel to one inverted bit of the index
  assign w_bar     = 3'(({21'd0, oX} << 3) / 32'(H_ACTIVE));
  assign w_bar_rgb = {{CW{~w_bar[1]}}, {CW{~w_bar[2]}}, {CW{~w_bar[0]}}};

  generate
    if (CW <= 8) begin : g_uf_narrow
      assign w_uf_rgb = {UNDERFLOW_RGB[23 -: CW], UNDERFLOW_RGB[15 -: CW], UNDERFLOW_RGB[7 -: CW]};
    end else begin : g_uf_wide
      assign w_uf_rgb = {UNDERFLOW_RGB[23:16], {(CW-8){1'b0}},
                         UNDERFLOW_RGB[15:8],  {(CW-8){1'b0}},
                         UNDERFLOW_RGB[7:0],   {(CW-8){1'b0}}};
    end
  endgenerate

  assign w_uf_evt = w_active && (r_mode == 2'd1) && !iDATA_VALID;

  always_comb begin
    w_pix = '0;
    if (w_active) begin
      case (r_mode)
        2'd0:    w_pix = iSOLID;
        2'd1:    w_pix = iDATA_VALID ? iDATA : w_uf_rgb;
        2'd2:    w_pix = w_bar_rgb;
        default: w_pix = iOVL_KEY ? iSOLID : iOVL;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_x         <= '0;
      r_y         <= '0;
      r_mode      <= 2'd0;
      r_uf        <= 1'b0;
      r_frame_cnt <= '0;
      r_s1_pix    <= '0;
      r_s1_de     <= 1'b0;
      r_s1_hd     <= 1'b1;
      r_s1_vd     <= 1'b1;
      oDE         <= 1'b0;
      oHD         <= 1'b1;
      oVD         <= 1'b1;
      oLCD_R      <= '0;
      oLCD_G      <= '0;
      oLCD_B      <= '0;
    end else begin
      if (r_x == c_xw'(c_h_total - 1)) begin
        r_x <= '0;
        r_y <= (r_y == c_yw'(c_v_total - 1)) ? '0 : r_y + c_yw'(1);
      end else begin
        r_x <= r_x + c_xw'(1);
      end
      // Mode only changes on a frame boundary so a frame is never mixed
      if (oNewFrame) r_mode <= iMODE;
      if (w_uf_evt)      r_uf <= 1'b1;
      else if (iCLR_ERR) r_uf <= 1'b0;
      if (oEndFrame) r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
      r_s1_pix <= w_pix;
      r_s1_de  <= w_active;
      r_s1_hd  <= (r_x >= c_xw'(H_SYNC));
      r_s1_vd  <= (r_y >= c_yw'(V_SYNC));
      oDE      <= r_s1_de;
      oHD      <= r_s1_hd;
      oVD      <= r_s1_vd;
      {oLCD_R, oLCD_G, oLCD_B} <= r_s1_pix;
    end
  end

  assign oUNDERFLOW = r_uf;
  assign oFRAME_CNT = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mtl_timing_gen_param.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mtl_timing_gen_param                                       |
// | Purpose  : Self-checking bench with a frame-position reference model.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_mtl_timing_gen_param;
  localparam int HA = 8, HB = 4, HF = 2, HS = 2, VA = 4, VB = 2, VF = 1, VS = 1, FL = 2;
  localparam int HT = HB + HA + HF;
  localparam int VT = VB + VA + VF;
  localparam int FT = HT * VT;
  localparam int END_POS = (VB + VA - 1) * HT + HB + HA - 1;
  localparam logic [26:0] RST_PIX = {3'b011, 24'h0};

  logic        iCLK = 1'b0, iRST = 1'b1;
  logic [1:0]  iMODE = 2'd0;
  logic [23:0] iSOLID = '0, iDATA = '0, iOVL = '0;
  logic        iDATA_VALID = 1'b0, iOVL_KEY = 1'b0, iCLR_ERR = 1'b0;
  logic        oREQ, oNewFrame, oEndFrame, oHD, oVD, oDE, oUNDERFLOW;
  logic [10:0] oX;
  logic [9:0]  oY;
  logic [7:0]  oLCD_R, oLCD_G, oLCD_B;
  logic [15:0] oFRAME_CNT;
  logic [26:0] obs;

  mtl_timing_gen_param #(
    .H_ACTIVE(HA), .H_BLANK(HB), .H_FP(HF), .H_SYNC(HS),
    .V_ACTIVE(VA), .V_BLANK(VB), .V_FP(VF), .V_SYNC(VS),
    .CW(8), .FETCH_LAT(FL), .FRAME_W(16), .UNDERFLOW_RGB(24'hFF00FF)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iMODE(iMODE), .iSOLID(iSOLID), .iDATA(iDATA),
    .iDATA_VALID(iDATA_VALID), .iOVL(iOVL), .iOVL_KEY(iOVL_KEY), .iCLR_ERR(iCLR_ERR),
    .oREQ(oREQ), .oX(oX), .oY(oY), .oNewFrame(oNewFrame), .oEndFrame(oEndFrame),
    .oHD(oHD), .oVD(oVD), .oDE(oDE), .oLCD_R(oLCD_R), .oLCD_G(oLCD_G), .oLCD_B(oLCD_B),
    .oUNDERFLOW(oUNDERFLOW), .oFRAME_CNT(oFRAME_CNT)
  );

  always #5 iCLK = ~iCLK;
  assign obs = {oDE, oHD, oVD, oLCD_R, oLCD_G, oLCD_B};

  int          n_pass = 0, n_total = 0;
  int          L = 0;
  int          mode_m = 0;
  bit          uf_m = 1'b0;
  logic [15:0] fc_m = '0;
  logic [26:0] pipe1 = RST_PIX, pipe2 = RST_PIX;
  int          req_q[$];
  int          drop_L = -1;
  logic [7:0]  salt;

  function automatic logic [23:0] bar_rgb(int px);
    case ((px * 8) / HA)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] ramp(int p);
    return {8'(p * 32 + int'(salt)), 8'(64 + p), 8'(240 - p)};
  endfunction

  function automatic bit pos_active(int l);
    int x, y;
    x = l % HT;
    y = (l / HT) % VT;
    return (x >= HB) && (x < HB + HA) && (y >= VB) && (y < VB + VA);
  endfunction

  function automatic bit exp_req(int l);
    int x, y;
    x = l % HT;
    y = (l / HT) % VT;
    return (mode_m == 1) && (y >= VB) && (y < VB + VA) && (x + FL >= HB) && (x + FL < HB + HA);
  endfunction

  task automatic model_reset();
    L = 0; mode_m = 0; uf_m = 1'b0; fc_m = '0;
    pipe1 = RST_PIX; pipe2 = RST_PIX;
    req_q.delete();
  endtask

  // Advance one pixel clock and update the reference model for the pixel just sampled
  task automatic tick();
    int x, y;
    bit act;
    logic [23:0] c;
    x = L % HT;
    y = (L / HT) % VT;
    act = pos_active(L);
    c = '0;
    if (act) begin
      case (mode_m)
        0: c = iSOLID;
        1: c = iDATA_VALID ? iDATA : 24'hFF00FF;
        2: c = bar_rgb(x - HB);
        default: c = iOVL_KEY ? iSOLID : iOVL;
      endcase
    end
    pipe2 = pipe1;
    pipe1 = {act, x >= HS, y >= VS, c};
    if (act && mode_m == 1 && !iDATA_VALID) uf_m = 1'b1;
    else if (iCLR_ERR) uf_m = 1'b0;
    if (L % FT == END_POS) fc_m = fc_m + 16'd1;
    if (L % FT == 0) mode_m = int'(iMODE);
    @(posedge iCLK);
    L++;
    @(negedge iCLK);
  endtask

  // Stream source: answers each request FL clocks later with a column ramp
  task automatic cycle();
    if (oREQ) req_q.push_back(L + FL);
    while (req_q.size() > 0 && req_q[0] < L) void'(req_q.pop_front());
    iDATA_VALID = 1'b0;
    iDATA = 24'($urandom);
    if (req_q.size() > 0 && req_q[0] == L) begin
      void'(req_q.pop_front());
      iDATA = ramp((L % HT) - HB);
      iDATA_VALID = (L != drop_L);
    end
    tick();
  endtask

  task automatic align();
    for (int i = 0; i < FT && (L % FT) != 0; i++) cycle();
  endtask

  task automatic test_reset();
    iRST = 1'b1;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK);
    n_total++; if (obs !== RST_PIX) $display("FAIL reset_pix: got %h expected %h", obs, RST_PIX); else n_pass++;
    n_total++; if ({oREQ, oUNDERFLOW, oFRAME_CNT} !== 18'd0) $display("FAIL reset_flags: got %h expected 0", {oREQ, oUNDERFLOW, oFRAME_CNT}); else n_pass++;
    iRST = 1'b0;
    model_reset();
    n_total++; if ({oNewFrame, oX, oY} !== {1'b1, 21'd0}) $display("FAIL reset_newframe: got %h expected %h", {oNewFrame, oX, oY}, {1'b1, 21'd0}); else n_pass++;
    tick();
    n_total++; if (oNewFrame !== 1'b0) $display("FAIL reset_newframe_drop: got %b expected 0", oNewFrame); else n_pass++;
  endtask

  task automatic test_timing();
    int f, de_cnt, hd_lo, vd_lo, nf;
    logic [22:0] ec;
    de_cnt = 0; hd_lo = 0; vd_lo = 0; nf = 0;
    iMODE = 2'd0;
    iSOLID = 24'h123456;
    align();
    f = L;
    for (int i = 0; i < 2 * FT + 2; i++) begin
      ec = {L % FT == 0, L % FT == END_POS,
            pos_active(L) ? 11'((L % HT) - HB) : 11'd0,
            pos_active(L) ? 10'(((L / HT) % VT) - VB) : 10'd0};
      n_total++; if ({oNewFrame, oEndFrame, oX, oY} !== ec) $display("FAIL timing_counter L=%0d: got %h expected %h", L, {oNewFrame, oEndFrame, oX, oY}, ec); else n_pass++;
      if (i < 2 * FT) nf += int'(oNewFrame);
      tick();
      n_total++; if (obs !== pipe2) $display("FAIL timing_pix L=%0d: got %h expected %h", L, obs, pipe2); else n_pass++;
      if (L - 2 >= f && L - 2 < f + 2 * FT) begin
        de_cnt += int'(oDE);
        hd_lo  += int'(!oHD);
        vd_lo  += int'(!oVD);
        if (oDE) begin
          n_total++; if ({oLCD_R, oLCD_G, oLCD_B} !== 24'h123456) $display("FAIL timing_solid: got %h expected 123456", {oLCD_R, oLCD_G, oLCD_B}); else n_pass++;
        end
      end
    end
    n_total++; if (de_cnt != 2 * VA * HA) $display("FAIL timing_de_count: got %0d expected %0d", de_cnt, 2 * VA * HA); else n_pass++;
    n_total++; if (hd_lo != 2 * VT * HS) $display("FAIL timing_hd_count: got %0d expected %0d", hd_lo, 2 * VT * HS); else n_pass++;
    n_total++; if (vd_lo != 2 * VS * HT) $display("FAIL timing_vd_count: got %0d expected %0d", vd_lo, 2 * VS * HT); else n_pass++;
    n_total++; if (nf != 2) $display("FAIL timing_newframe_count: got %0d expected 2", nf); else n_pass++;
  endtask

  task automatic test_stream();
    int nreq, nfirst;
    nreq = 0; nfirst = 0;
    iMODE = 2'd1;
    align();
    for (int i = 0; i < FT + 2; i++) begin
      n_total++; if (oREQ !== exp_req(L)) $display("FAIL stream_req L=%0d: got %b expected %b", L, oREQ, exp_req(L)); else n_pass++;
      if (i < FT && oREQ) begin
        nreq++;
        if (L % HT == HB - FL) nfirst++;
      end
      cycle();
      n_total++; if (obs !== pipe2) $display("FAIL stream_pix L=%0d: got %h expected %h", L, obs, pipe2); else n_pass++;
      if (oDE) begin
        n_total++; if ({oLCD_R, oLCD_G, oLCD_B} !== ramp(((L - 2) % HT) - HB)) $display("FAIL stream_ramp L=%0d: got %h expected %h", L, {oLCD_R, oLCD_G, oLCD_B}, ramp(((L - 2) % HT) - HB)); else n_pass++;
      end
    end
    n_total++; if (nreq != VA * HA) $display("FAIL stream_req_count: got %0d expected %0d", nreq, VA * HA); else n_pass++;
    n_total++; if (nfirst != VA) $display("FAIL stream_first_req: got %0d expected %0d", nfirst, VA); else n_pass++;
    n_total++; if (oUNDERFLOW !== 1'b0) $display("FAIL stream_no_underflow: got %b expected 0", oUNDERFLOW); else n_pass++;
  endtask

  task automatic test_underflow();
    int f;
    align();
    f = L;
    drop_L = f + 2 * HT + HB + 2;
    for (int i = 0; i < FT && L < drop_L + 2; i++) begin
      cycle();
      n_total++; if (obs !== pipe2) $display("FAIL uf_pix L=%0d: got %h expected %h", L, obs, pipe2); else n_pass++;
    end
    n_total++; if ({oDE, oLCD_R, oLCD_G, oLCD_B} !== {1'b1, 24'hFF00FF}) $display("FAIL uf_colour: got %h expected %h", {oDE, oLCD_R, oLCD_G, oLCD_B}, {1'b1, 24'hFF00FF}); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_total++; if (oUNDERFLOW !== 1'b1) $display("FAIL uf_sticky L=%0d: got %b expected 1", L, oUNDERFLOW); else n_pass++;
    end
    iCLR_ERR = 1'b1;
    cycle();
    iCLR_ERR = 1'b0;
    n_total++; if (oUNDERFLOW !== uf_m || uf_m !== 1'b0) $display("FAIL uf_clear: got %b expected 0", oUNDERFLOW); else n_pass++;
    drop_L = f + 4 * HT + HB + 5;
    for (int i = 0; i < FT && L < drop_L; i++) cycle();
    iCLR_ERR = 1'b1;
    cycle();
    iCLR_ERR = 1'b0;
    n_total++; if (oUNDERFLOW !== 1'b1) $display("FAIL uf_clear_vs_set: got %b expected 1", oUNDERFLOW); else n_pass++;
    drop_L = -1;
    for (int i = 0; i < FT && L < f + FT + 2; i++) begin
      cycle();
      n_total++; if (obs !== pipe2) $display("FAIL uf_tail L=%0d: got %h expected %h", L, obs, pipe2); else n_pass++;
    end
  endtask

  task automatic test_mode_switch();
    int f, p;
    logic [23:0] e;
    iMODE = 2'd0;
    iSOLID = 24'($urandom) | 24'h1;
    align();
    f = L;
    for (int i = 0; i < 2 * FT + 2; i++) begin
      if (L == f + 3 * HT) iMODE = 2'd2;
      cycle();
      n_total++; if (obs !== pipe2) $display("FAIL mode_pix L=%0d: got %h expected %h", L, obs, pipe2); else n_pass++;
      if (oDE) begin
        p = L - 2;
        e = (p < f + FT) ? iSOLID : bar_rgb((p % HT) - HB);
        n_total++; if ({oLCD_R, oLCD_G, oLCD_B} !== e) $display("FAIL mode_colour L=%0d: got %h expected %h", L, {oLCD_R, oLCD_G, oLCD_B}, e); else n_pass++;
      end
    end
  endtask

  task automatic test_overlay();
    int p;
    logic [23:0] e;
    iMODE = 2'd3;
    iOVL = 24'hAA0000;
    iSOLID = 24'($urandom) | 24'h1;
    align();
    for (int i = 0; i < FT + 2; i++) begin
      iOVL_KEY = ((L % HT) < HB + 4);
      cycle();
      n_total++; if (obs !== pipe2) $display("FAIL ovl_pix L=%0d: got %h expected %h", L, obs, pipe2); else n_pass++;
      if (oDE) begin
        p = ((L - 2) % HT) - HB;
        e = (p < 4) ? iSOLID : 24'hAA0000;
        n_total++; if ({oLCD_R, oLCD_G, oLCD_B} !== e) $display("FAIL ovl_colour L=%0d: got %h expected %h", L, {oLCD_R, oLCD_G, oLCD_B}, e); else n_pass++;
      end
    end
    n_total++; if (oUNDERFLOW !== uf_m) $display("FAIL ovl_uf_hold: got %b expected %b", oUNDERFLOW, uf_m); else n_pass++;
  endtask

  task automatic test_frame_reset();
    iRST = 1'b1;
    @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    model_reset();
    n_total++; if (oFRAME_CNT !== 16'd0) $display("FAIL fc_reset: got %0d expected 0", oFRAME_CNT); else n_pass++;
    iMODE = 2'd1;
    drop_L = 2 * HT + HB;
    for (int i = 0; i < 3 * FT; i++) cycle();
    drop_L = -1;
    n_total++; if (oFRAME_CNT !== 16'd3 || fc_m !== 16'd3) $display("FAIL fc_three: got %0d expected 3", oFRAME_CNT); else n_pass++;
    n_total++; if (oUNDERFLOW !== 1'b1) $display("FAIL fc_uf_set: got %b expected 1", oUNDERFLOW); else n_pass++;
    for (int i = 0; i < FT && L < 3 * FT + 3 * HT + HB + 4; i++) cycle();
    n_total++; if (obs !== pipe2 || oDE !== 1'b1) $display("FAIL pre_reset_pix: got %h expected %h", obs, pipe2); else n_pass++;
    #2 iRST = 1'b1;
    #1;
    n_total++; if (obs !== RST_PIX) $display("FAIL async_reset_pix: got %h expected %h", obs, RST_PIX); else n_pass++;
    n_total++; if ({oREQ, oUNDERFLOW, oFRAME_CNT, oX, oY} !== 39'd0) $display("FAIL async_reset_state: got %h expected 0", {oREQ, oUNDERFLOW, oFRAME_CNT, oX, oY}); else n_pass++;
    @(posedge iCLK);
    @(negedge iCLK);
    iRST = 1'b0;
    model_reset();
    n_total++; if (oNewFrame !== 1'b1) $display("FAIL release_newframe: got %b expected 1", oNewFrame); else n_pass++;
    tick();
    n_total++; if ({oNewFrame, obs} !== {1'b0, pipe2}) $display("FAIL release_step: got %h expected %h", {oNewFrame, obs}, {1'b0, pipe2}); else n_pass++;
  endtask

  initial begin
    salt = 8'($urandom);
    test_reset();
    test_timing();
    test_stream();
    test_underflow();
    test_mode_switch();
    test_overlay();
    test_frame_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
